// File: rtl/wb_ddr2_pkg.sv
// Shared types and constants for the DDR2 posted-write buffer.
//   wbuf_state_t : controller states (idle, draining a write, bus gap, read pass-through)
//   CTI_* / BTE_*: Wishbone cycle-type and burst-type encodings
//   wbuf_entry_t : one queued write {adr, sel, dat} at the default 32-bit widths;
//                  the queue packs entries in this field order, MSB first
package wb_ddr2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_GAP   = 2'd2,
    ST_READ  = 2'd3
  } wbuf_state_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_EOB     = 3'b111;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  localparam int ENTRY_AW = 32;
  localparam int ENTRY_DW = 32;

  typedef struct packed {
    logic [ENTRY_AW-1:0]   adr;
    logic [ENTRY_DW/8-1:0] sel;
    logic [ENTRY_DW-1:0]   dat;
  } wbuf_entry_t;

endpackage

// File: rtl/wb_wbuf_fifo.sv
// Synchronous FIFO holding posted write entries.
//   clk, rst_n : clock, asynchronous active-low reset (empties the queue)
//   push_i     : write din_i; ignored while full
//   pop_i      : drop the head entry; ignored while empty
//   dout_o     : head entry, valid whenever empty_o is low
//   full_o, empty_o, level_o : occupancy, level_o ranges 0..DEPTH
module wb_wbuf_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 68
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             din_i,
  output logic [W-1:0]             dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          push_ok, pop_ok;

  // Full is judged on the current level, so a full queue refuses a push
  // even in the cycle it pops.
  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // NOTE: storage is left unreset; emptiness is tracked by the pointers and
  // level alone, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

endmodule

// File: rtl/wb_ddr2_wbuf.sv
// Posted-write buffer in front of one DDR2 wrapper master port.
//   wb_clk, wb_rst_n : clock, asynchronous active-low reset
//   wbs_*            : upstream Wishbone slave; single writes are acked one
//                      cycle after acceptance and queued
//   wbm_*            : downstream Wishbone master; drains the queue as classic
//                      single writes, or mirrors upstream during a read
//   wr_err_o         : sticky, a posted write was answered with err
//   level_o          : queue occupancy
// Reads are only forwarded once the queue is empty, so they observe every
// earlier posted write.
module wb_ddr2_wbuf
  import wb_ddr2_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                   wb_clk,
  input  logic                   wb_rst_n,
  input  logic [AW-1:0]          wbs_adr_i,
  input  logic [DW-1:0]          wbs_dat_i,
  input  logic [DW/8-1:0]        wbs_sel_i,
  input  logic [2:0]             wbs_cti_i,
  input  logic [1:0]             wbs_bte_i,
  input  logic                   wbs_cyc_i,
  input  logic                   wbs_stb_i,
  input  logic                   wbs_we_i,
  output logic [DW-1:0]          wbs_dat_o,
  output logic                   wbs_ack_o,
  output logic                   wbs_err_o,
  output logic                   wbs_rty_o,
  output logic [AW-1:0]          wbm_adr_o,
  output logic [DW-1:0]          wbm_dat_o,
  output logic [DW/8-1:0]        wbm_sel_o,
  output logic [2:0]             wbm_cti_o,
  output logic [1:0]             wbm_bte_o,
  output logic                   wbm_cyc_o,
  output logic                   wbm_stb_o,
  output logic                   wbm_we_o,
  input  logic [DW-1:0]          wbm_dat_i,
  input  logic                   wbm_ack_i,
  input  logic                   wbm_err_i,
  input  logic                   wbm_rty_i,
  output logic                   wr_err_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int SW = DW / 8;
  localparam int EW = AW + SW + DW;

  wbuf_state_t   state_q, state_d;
  logic          ack_q, ack_d;
  logic          wr_err_q, wr_err_d;
  logic          push, pop;
  logic          fifo_full, fifo_empty;
  logic [EW-1:0] head;
  logic [AW-1:0] head_adr;
  logic [SW-1:0] head_sel;
  logic [DW-1:0] head_dat;
  logic          wr_req, rd_req;

  assign wr_req = wbs_cyc_i & wbs_stb_i & wbs_we_i;
  assign rd_req = wbs_cyc_i & wbs_stb_i & ~wbs_we_i;

  // The ack cycle itself never accepts, so a held strobe is not queued twice.
  assign push  = wr_req & ~fifo_full & ~ack_q & (state_q != ST_READ);
  assign ack_d = push;

  assign {head_adr, head_sel, head_dat} = head;

  wb_wbuf_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk     (wb_clk),
    .rst_n   (wb_rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   ({wbs_adr_i, wbs_sel_i, wbs_dat_i}),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level_o)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    wr_err_d  = wr_err_q;
    wbm_adr_o = '0;
    wbm_dat_o = '0;
    wbm_sel_o = '0;
    wbm_cti_o = '0;
    wbm_bte_o = '0;
    wbm_cyc_o = 1'b0;
    wbm_stb_o = 1'b0;
    wbm_we_o  = 1'b0;
    wbs_ack_o = ack_q;
    wbs_err_o = 1'b0;
    wbs_dat_o = '0;

    case (state_q)
      ST_IDLE: begin
        // Queued writes win over a waiting read; the read is held unacked.
        if (!fifo_empty)         state_d = ST_WRITE;
        else if (!ack_q && rd_req) state_d = ST_READ;
      end
      ST_WRITE: begin
        wbm_cyc_o = 1'b1;
        wbm_stb_o = 1'b1;
        wbm_we_o  = 1'b1;
        wbm_cti_o = CTI_CLASSIC;
        wbm_bte_o = BTE_LINEAR;
        wbm_adr_o = head_adr;
        wbm_sel_o = head_sel;
        wbm_dat_o = head_dat;
        if (wbm_ack_i || wbm_err_i) begin
          pop     = 1'b1;
          state_d = ST_GAP;
          if (!wbm_ack_i) wr_err_d = 1'b1;
        end else if (wbm_rty_i) begin
          // Head stays queued and is reissued after the gap.
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        // One idle bus cycle lets the wrapper rearbitrate.
        state_d = ST_IDLE;
      end
      ST_READ: begin
        wbm_adr_o = wbs_adr_i;
        wbm_dat_o = wbs_dat_i;
        wbm_sel_o = wbs_sel_i;
        wbm_cti_o = wbs_cti_i;
        wbm_bte_o = wbs_bte_i;
        wbm_cyc_o = wbs_cyc_i;
        wbm_stb_o = wbs_stb_i;
        wbm_we_o  = wbs_we_i;
        wbs_ack_o = wbm_ack_i;
        wbs_err_o = wbm_err_i;
        wbs_dat_o = wbm_dat_i;
        if (!wbs_cyc_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q  <= ST_IDLE;
      ack_q    <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ack_q    <= ack_d;
      wr_err_q <= wr_err_d;
    end
  end

  assign wr_err_o  = wr_err_q;
  assign wbs_rty_o = 1'b0;

endmodule

// File: tb/tb_wb_ddr2_wbuf.sv
// Scoreboard bench for wb_ddr2_wbuf: an upstream driver, a behavioural
// downstream slave (addresses with bit 12 set answer err) and a monitor that
// checks every downstream write beat, forwarded read and read response.
module tb_wb_ddr2_wbuf;
  import wb_ddr2_pkg::*;

  localparam int DEPTH = 4;

  logic        wb_clk = 1'b0;
  logic        wb_rst_n = 1'b0;
  logic [31:0] wbs_adr_i = '0, wbs_dat_i = '0;
  logic [3:0]  wbs_sel_i = '0;
  logic [2:0]  wbs_cti_i = '0;
  logic [1:0]  wbs_bte_i = '0;
  logic        wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
  logic [31:0] wbs_dat_o;
  logic        wbs_ack_o, wbs_err_o, wbs_rty_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic [2:0]  wbm_cti_o;
  logic [1:0]  wbm_bte_o;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [31:0] wbm_dat_i = '0;
  logic        wbm_ack_i = 1'b0, wbm_err_i = 1'b0, wbm_rty_i = 1'b0;
  logic        wr_err_o;
  logic [2:0]  level_o;

  always #5 wb_clk = ~wb_clk;

  wb_ddr2_wbuf #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
    .wb_clk(wb_clk), .wb_rst_n(wb_rst_n),
    .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_sel_i(wbs_sel_i),
    .wbs_cti_i(wbs_cti_i), .wbs_bte_i(wbs_bte_i), .wbs_cyc_i(wbs_cyc_i),
    .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i), .wbs_dat_o(wbs_dat_o),
    .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o), .wbs_rty_o(wbs_rty_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
    .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o), .wbm_cyc_o(wbm_cyc_o),
    .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o), .wbm_dat_i(wbm_dat_i),
    .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i), .wbm_rty_i(wbm_rty_i),
    .wr_err_o(wr_err_o), .level_o(level_o)
  );

  int total = 0;
  int bad = 0;

  // Reference model: committed memory plus posted writes not yet drained.
  wbuf_entry_t exp_wq[$];
  logic [31:0] exp_rq[$];
  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] slv_mem[logic [31:0]];
  bit          exp_wr_err = 1'b0;
  bit          slave_stall = 1'b1;
  bit          force_rty = 1'b0;
  bit          rand_rty = 1'b0;
  bit          rd_active = 1'b0;
  bit          rd_seen = 1'b0;
  bit          gap_pending = 1'b0;
  bit          done5 = 1'b0;
  logic [31:0] rd_adr = '0;
  int          n_rty_seen = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_init(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] s);
    logic [31:0] r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  function automatic bit is_err_adr(input logic [31:0] a);
    return a[12];
  endfunction

  // A read sees memory after every earlier posted write has landed.
  function automatic logic [31:0] ref_read(input logic [31:0] a);
    logic [31:0] v = ref_mem.exists(a) ? ref_mem[a] : mem_init(a);
    foreach (exp_wq[i])
      if (exp_wq[i].adr == a && !is_err_adr(a)) v = merge(v, exp_wq[i].dat, exp_wq[i].sel);
    return v;
  endfunction

  // Downstream slave: answers after a random delay; can stall or force rty.
  initial begin
    logic [31:0] a;
    forever begin
      @(posedge wb_clk);
      #2;
      wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wbm_rty_i = 1'b0; wbm_dat_i = '0;
      if (wb_rst_n && wbm_cyc_o && wbm_stb_o && !slave_stall && $urandom_range(0, 2) != 0) begin
        a = wbm_adr_o;
        if (wbm_we_o) begin
          if (is_err_adr(a)) wbm_err_i = 1'b1;
          else if (force_rty || (rand_rty && $urandom_range(0, 3) == 0)) begin
            wbm_rty_i = 1'b1;
            force_rty = 1'b0;
          end else begin
            wbm_ack_i = 1'b1;
            slv_mem[a] = merge(slv_mem.exists(a) ? slv_mem[a] : mem_init(a), wbm_dat_o, wbm_sel_o);
          end
        end else begin
          wbm_ack_i = 1'b1;
          wbm_dat_i = slv_mem.exists(a) ? slv_mem[a] : mem_init(a);
        end
      end
    end
  end

  // Monitor: compares whatever the DUT presents against the scoreboard.
  initial begin
    wbuf_entry_t h;
    forever begin
      @(negedge wb_clk);
      if (!wb_rst_n) begin
        gap_pending = 1'b0;
      end else begin
        if (gap_pending) begin
          check("gap_cyc_low", 96'(wbm_cyc_o), 96'(0));
          gap_pending = 1'b0;
        end
        if (wbm_cyc_o && wbm_stb_o && wbm_we_o && (wbm_ack_i || wbm_err_i || wbm_rty_i)) begin
          gap_pending = 1'b1;
          if (exp_wq.size() == 0) begin
            total++; bad++;
            $display("FAIL wr_unexpected actual=%0h expected=none", wbm_adr_o);
          end else begin
            h = exp_wq[0];
            check("wr_beat", {wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_cti_o, wbm_bte_o},
                  {h.adr, h.dat, h.sel, CTI_CLASSIC, BTE_LINEAR});
            if (wbm_rty_i) n_rty_seen++;
            else begin
              if (wbm_err_i) exp_wr_err = 1'b1;
              else ref_mem[h.adr] = merge(ref_mem.exists(h.adr) ? ref_mem[h.adr] : mem_init(h.adr),
                                          h.dat, h.sel);
              void'(exp_wq.pop_front());
            end
          end
        end
        if (wbm_cyc_o && wbm_stb_o && !wbm_we_o && !rd_seen) begin
          rd_seen = 1'b1;
          check("rd_after_drain", {32'(exp_wq.size()), 29'(0), level_o}, 96'(0));
          check("rd_fwd", {wbm_adr_o, wbm_cti_o, wbm_sel_o}, {rd_adr, CTI_EOB, 4'hF});
        end
        if (rd_active && wbs_ack_o) begin
          check("rd_ack_passthru", 96'(wbm_ack_i), 96'(1));
          if (exp_rq.size() == 0) begin
            total++; bad++;
            $display("FAIL rd_unexpected actual=%0h expected=none", wbs_dat_o);
          end else check("rd_data", 96'(wbs_dat_o), 96'(exp_rq.pop_front()));
        end
      end
    end
  end

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output int lat);
    @(posedge wb_clk); #1;
    wbs_adr_i = a; wbs_dat_i = d; wbs_sel_i = s; wbs_cti_i = CTI_CLASSIC;
    wbs_we_i = 1'b1; wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
    exp_wq.push_back('{adr: a, sel: s, dat: d});
    lat = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge wb_clk);
      if (wbs_ack_o) begin lat = i; break; end
    end
    if (lat < 0) begin
      total++; bad++;
      $display("FAIL wr_ack_timeout actual=none expected=ack adr=%0h", a);
    end
    @(posedge wb_clk); #1;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
  endtask

  task automatic wb_read(input logic [31:0] a);
    bit got = 1'b0;
    @(posedge wb_clk); #1;
    wbs_adr_i = a; wbs_sel_i = 4'hF; wbs_cti_i = CTI_EOB; wbs_we_i = 1'b0;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
    rd_adr = a; rd_seen = 1'b0;
    exp_rq.push_back(ref_read(a));
    rd_active = 1'b1;
    for (int i = 0; i < 600; i++) begin
      @(negedge wb_clk);
      if (wbs_ack_o) begin got = 1'b1; break; end
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL rd_ack_timeout actual=none expected=ack adr=%0h", a);
      exp_rq.delete();
    end
    @(posedge wb_clk); #1;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; rd_active = 1'b0; wbs_cti_i = CTI_CLASSIC;
    @(posedge wb_clk);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 800; i++) begin
      @(negedge wb_clk);
      if (exp_wq.size() == 0 && level_o == 0 && !wbm_cyc_o) break;
    end
    check({tag, "_drain_q"}, 96'(exp_wq.size()), 96'(0));
    check({tag, "_drain_level"}, 96'(level_o), 96'(0));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int k;
    logic [31:0] a;

    // Reset state
    #1;
    check("reset_outs", {wbs_ack_o, wbs_err_o, wbs_rty_o, wbm_cyc_o, wbm_stb_o, wbm_we_o,
                         wr_err_o, level_o, wbm_adr_o, wbs_dat_o}, 96'(0));
    repeat (3) @(posedge wb_clk);
    #3 wb_rst_n = 1'b1;

    // 1: single posted write, ack at N+1, downstream beat at N+2
    slave_stall = 1'b1;
    @(posedge wb_clk); #1;
    wbs_adr_i = 32'h100; wbs_dat_i = 32'hDEAD_BEEF; wbs_sel_i = 4'hF;
    wbs_we_i = 1'b1; wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
    exp_wq.push_back('{adr: 32'h100, sel: 4'hF, dat: 32'hDEAD_BEEF});
    @(negedge wb_clk);
    check("t1_ack_n", 96'(wbs_ack_o), 96'(0));
    @(negedge wb_clk);
    check("t1_ack_n1", {wbs_ack_o, wbm_cyc_o, level_o}, {1'b1, 1'b0, 3'd1});
    @(posedge wb_clk); #1;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    @(negedge wb_clk);
    check("t1_beat_n2", {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_cti_o, wbm_bte_o, wbm_adr_o, wbs_ack_o},
          {1'b1, 1'b1, 1'b1, CTI_CLASSIC, BTE_LINEAR, 32'h100, 1'b0});
    slave_stall = 1'b0;
    wait_drain("t1");

    // 2: fill to DEPTH with the slave stalled, fifth write stalls
    slave_stall = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      wb_write(32'h500 + 32'(4 * i), $urandom, 4'hF, lat);
      check("t2_wr_latency", 96'(lat), 96'(1));
    end
    done5 = 1'b0;
    fork
      begin
        int l5;
        wb_write(32'h510, 32'h5555_0005, 4'hF, l5);
        done5 = 1'b1;
      end
    join_none
    repeat (8) @(negedge wb_clk);
    check("t2_full_level", 96'(level_o), 96'(DEPTH));
    check("t2_fifth_stalled", 96'(done5), 96'(0));
    slave_stall = 1'b0;
    for (int i = 0; i < 100 && !done5; i++) @(negedge wb_clk);
    check("t2_fifth_acked", 96'(done5), 96'(1));
    repeat (2) @(posedge wb_clk);
    wait_drain("t2");

    // 3: read after a posted write sees the written data
    wb_write(32'h200, 32'h1234_5678, 4'hF, lat);
    wb_read(32'h200);

    // 4: err on the first of two queued writes
    slave_stall = 1'b1;
    wb_write(32'h1000, 32'hBAD0_0001, 4'hF, lat);
    wb_write(32'h204, 32'h0000_0204, 4'h3, lat);
    slave_stall = 1'b0;
    wait_drain("t4");
    check("t4_wr_err", 96'(wr_err_o), 96'(1));
    repeat (5) @(negedge wb_clk);
    check("t4_wr_err_sticky", 96'(wr_err_o), 96'(exp_wr_err));

    // 5: rty leaves the head queued and reissues it
    force_rty = 1'b1;
    k = n_rty_seen;
    wb_write(32'h300, 32'h0300_0300, 4'hF, lat);
    for (int i = 0; i < 100 && n_rty_seen == k; i++) @(negedge wb_clk);
    check("t5_rty_seen", 96'(n_rty_seen - k), 96'(1));
    @(negedge wb_clk);
    check("t5_level_kept", {wbm_cyc_o, level_o}, {1'b0, 3'd1});
    wait_drain("t5");
    wb_read(32'h300);

    // 6: asynchronous reset with writes pending and a downstream cycle open
    slave_stall = 1'b1;
    for (int i = 0; i < 3; i++) wb_write(32'h600 + 32'(4 * i), $urandom, 4'hF, lat);
    for (int i = 0; i < 20 && !wbm_cyc_o; i++) @(negedge wb_clk);
    #2 wb_rst_n = 1'b0;
    #1;
    check("t6_async_reset", {wbs_ack_o, wbm_cyc_o, wbm_stb_o, wbm_we_o, wr_err_o, level_o,
                             wbm_adr_o, wbm_dat_o}, 96'(0));
    exp_wq.delete();
    exp_wr_err = 1'b0;
    repeat (2) @(posedge wb_clk);
    #3 wb_rst_n = 1'b1;
    slave_stall = 1'b0;
    k = 0;
    repeat (6) begin
      @(negedge wb_clk);
      if (wbm_cyc_o || level_o != 0) k++;
    end
    check("t6_quiet_after_reset", 96'(k), 96'(0));
    wb_write(32'h600, 32'h0600_CAFE, 4'hF, lat);
    wait_drain("t6");
    wb_read(32'h604);

    // Random traffic with random slave delay and retries
    rand_rty = 1'b1;
    for (int n = 0; n < 60; n++) begin
      k = $urandom_range(0, 99);
      a = 32'h400 + 32'(4 * $urandom_range(0, 7));
      if (k < 60) wb_write(a, $urandom, 4'($urandom_range(1, 15)), lat);
      else if (k < 65) wb_write(32'h1000 + 32'(4 * $urandom_range(0, 3)), $urandom, 4'hF, lat);
      else wb_read(a);
    end
    wait_drain("rand");
    for (int i = 0; i < 8; i++) wb_read(32'h400 + 32'(4 * i));
    repeat (3) @(negedge wb_clk);
    check("rand_wr_err", 96'(wr_err_o), 96'(exp_wr_err));
    check("rand_rd_q_empty", 96'(exp_rq.size()), 96'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
